// File: rtl/fft_sched.sv
// fft_sched: ping-pong fill and 4-stage radix-2 DIT butterfly scheduler for a 16-point FFT.
// Optional FFT_SCHED_FRAME_CNT_EN adds frame_cnt and saturating drop_cnt outputs.
module fft_sched #(
  parameter int LOG2N  = 4,
  parameter int BF_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             data_valid,
  output logic             wr_en,
  output logic             wr_bank,
  output logic [LOG2N-1:0] wr_addr,
  output logic             cmp_bank,
  output logic             bf_start,
  output logic [LOG2N-1:0] bf_addr_a,
  output logic [LOG2N-1:0] bf_addr_b,
  output logic [LOG2N-2:0] tw_idx,
  output logic             bf_we,
  output logic [LOG2N-1:0] wb_addr_a,
  output logic [LOG2N-1:0] wb_addr_b,
  output logic             busy,
  output logic             fft_valid,
  output logic             overrun
`ifdef FFT_SCHED_FRAME_CNT_EN
  ,
  output logic [15:0]      frame_cnt,
  output logic [7:0]       drop_cnt
`endif
);
  localparam int SW = (LOG2N > 1) ? $clog2(LOG2N) : 1;
  localparam int DW = $clog2(BF_LAT + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, OUT} state_t;
  state_t state_q, state_d;
  logic [LOG2N-1:0] fill_q, fill_d;
  logic wr_bank_q, wr_bank_d, cmp_bank_q, cmp_bank_d, pend_q, pend_d, hold_q, hold_d;
  logic [SW-1:0] s_q, s_d;
  logic [LOG2N-2:0] k_q, k_d;
  logic [DW-1:0] dc_q, dc_d;
  logic [2*LOG2N:0] pipe_q [BF_LAT];
  logic acc, fc, launch, issue;
  logic [LOG2N-1:0] kk, h, j, a;
  always_comb begin
    kk = LOG2N'(k_q);
    h = LOG2N'(1) << s_q;
    j = kk & (h - 1'b1);
    a = (((kk >> s_q) << s_q) << 1) + j;
    issue = state_q == ISSUE;
    bf_start = issue;
    bf_addr_a = issue ? a : '0;
    bf_addr_b = issue ? (a | h) : '0;
    tw_idx = issue ? (LOG2N-1)'(j << (LOG2N - 1 - s_q)) : '0;
    for (int i = 0; i < LOG2N; i++) wr_addr[i] = fill_q[LOG2N-1-i];
    acc = data_valid & ~hold_q;
    fc = acc & (fill_q == '1);
    launch = fc & ((state_q == IDLE) | (state_q == OUT));
    wr_en = rst & acc;
    overrun = rst & data_valid & hold_q;
    wr_bank = wr_bank_q;
    cmp_bank = cmp_bank_q;
    busy = state_q != IDLE;
    fft_valid = state_q == OUT;
    {bf_we, wb_addr_a, wb_addr_b} = pipe_q[BF_LAT-1];
  end
  always_comb begin
    state_d = state_q;
    fill_d = acc ? fill_q + 1'b1 : fill_q;
    wr_bank_d = wr_bank_q;
    cmp_bank_d = cmp_bank_q;
    pend_d = pend_q;
    hold_d = hold_q;
    s_d = s_q;
    k_d = k_q;
    dc_d = dc_q;
    if (fc && !launch) begin
      pend_d = 1'b1;
      hold_d = 1'b1;
    end
    case (state_q)
      ISSUE: begin
        k_d = k_q + 1'b1;
        if (k_q == '1) begin
          state_d = DRAIN;
          dc_d = '0;
        end
      end
      DRAIN: begin
        dc_d = dc_q + 1'b1;
        if (dc_q == DW'(BF_LAT - 1)) begin
          state_d = (s_q == SW'(LOG2N - 1)) ? OUT : ISSUE;
          s_d = (s_q == SW'(LOG2N - 1)) ? s_q : s_q + 1'b1;
        end
      end
      OUT: begin
        s_d = '0;
        state_d = pend_q ? ISSUE : IDLE;
        if (pend_q) begin
          pend_d = 1'b0;
          hold_d = 1'b0;
          cmp_bank_d = wr_bank_q;
          wr_bank_d = ~wr_bank_q;
        end
      end
      default: ;
    endcase
    if (launch) begin
      state_d = ISSUE;
      cmp_bank_d = wr_bank_q;
      wr_bank_d = ~wr_bank_q;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      fill_q <= '0;
      wr_bank_q <= 1'b0;
      cmp_bank_q <= 1'b0;
      pend_q <= 1'b0;
      hold_q <= 1'b0;
      s_q <= '0;
      k_q <= '0;
      dc_q <= '0;
    end else begin
      state_q <= state_d;
      fill_q <= fill_d;
      wr_bank_q <= wr_bank_d;
      cmp_bank_q <= cmp_bank_d;
      pend_q <= pend_d;
      hold_q <= hold_d;
      s_q <= s_d;
      k_q <= k_d;
      dc_q <= dc_d;
    end
  end
  // writeback strobe and addresses trail the issue by exactly BF_LAT cycles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < BF_LAT; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= {bf_start, bf_addr_a, bf_addr_b};
      for (int i = 1; i < BF_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end
`ifdef FFT_SCHED_FRAME_CNT_EN
  logic [15:0] frame_q;
  logic [7:0] drop_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_q <= '0;
      drop_q <= '0;
    end else begin
      if (fft_valid) frame_q <= frame_q + 1'b1;
      if (overrun && drop_q != '1) drop_q <= drop_q + 1'b1;
    end
  end
  assign frame_cnt = frame_q;
  assign drop_cnt = drop_q;
`endif
endmodule

// File: tb/tb_fft_sched.sv
// tb_fft_sched: timestamped scoreboard bench for fft_sched; a cycle model pushes expected events, a negedge monitor pops them.
module tb_fft_sched;
  logic clk = 1'b0, rst = 1'b0, dv = 1'b0;
  logic wr_en, wr_bank, cmp_bank, bf_start, bf_we, busy, fft_valid, overrun;
  logic [3:0] wr_addr, bf_addr_a, bf_addr_b, wb_addr_a, wb_addr_b;
  logic [2:0] tw_idx;
`ifdef FFT_SCHED_FRAME_CNT_EN
  logic [15:0] frame_cnt;
  logic [7:0] drop_cnt;
`endif
  fft_sched #(.LOG2N(4), .BF_LAT(2)) dut (
    .clk(clk), .rst(rst), .data_valid(dv),
    .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr),
    .cmp_bank(cmp_bank), .bf_start(bf_start), .bf_addr_a(bf_addr_a), .bf_addr_b(bf_addr_b),
    .tw_idx(tw_idx), .bf_we(bf_we), .wb_addr_a(wb_addr_a), .wb_addr_b(wb_addr_b),
    .busy(busy), .fft_valid(fft_valid), .overrun(overrun)
`ifdef FFT_SCHED_FRAME_CNT_EN
    , .frame_cnt(frame_cnt), .drop_cnt(drop_cnt)
`endif
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int nv = 0, nf = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nv++;
    if (got !== exp) begin
      nf++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask
  function automatic logic [63:0] pk(input int c, input logic [15:0] f);
    return {c, 16'h0, f};
  endfunction
  function automatic logic [3:0] br(input logic [3:0] f);
    return {f[0], f[1], f[2], f[3]};
  endfunction
  logic [63:0] wq[$], bq[$], wbq[$], fq[$], oq[$];
  logic [3:0] m_fill;
  logic m_bank, m_cmp, m_pend, m_hold;
  int m_out, m_frames, m_drops;
  task automatic model_reset();
    m_fill = 0; m_bank = 0; m_cmp = 0; m_pend = 0; m_hold = 0;
    m_out = -1; m_frames = 0; m_drops = 0;
    wq.delete(); bq.delete(); wbq.delete(); fq.delete(); oq.delete();
  endtask
  // butterfly order: groups of 2h points, j walks inside each group
  task automatic start(input int t);
    int k, h, tc;
    logic [3:0] a, b;
    logic [2:0] tw;
    m_cmp = m_bank;
    m_bank = ~m_bank;
    for (int s = 0; s < 4; s++) begin
      h = 1 << s;
      k = 0;
      for (int g = 0; g < 16; g += 2 * h)
        for (int j = 0; j < h; j++) begin
          a = 4'(g + j);
          b = 4'(g + j + h);
          tw = 3'(j * (8 / h));
          tc = t + 1 + 10 * s + k;
          bq.push_back(pk(tc, {3'b0, 1'b1, m_cmp, a, b, tw}));
          wbq.push_back(pk(tc + 2, {7'b0, 1'b1, a, b}));
          k++;
        end
    end
    m_out = t + 41;
  endtask
  initial begin
    int c;
    bit started, is_out;
    logic [63:0] e;
    model_reset();
    forever begin
      @(negedge clk);
      c = cyc;
      if (!rst) model_reset();
      chk("busy", busy, m_out >= 0);
`ifdef FFT_SCHED_FRAME_CNT_EN
      chk("drop_cnt", drop_cnt, m_drops);
`endif
      started = 0;
      is_out = (m_out == c);
      if (is_out) begin
        fq.push_back(pk(c, {14'b0, 1'b1, m_cmp}));
`ifdef FFT_SCHED_FRAME_CNT_EN
        chk("frame_cnt", frame_cnt, m_frames);
`endif
        m_frames++;
      end
      if (rst && dv) begin
        if (m_hold) begin
          oq.push_back(pk(c, 16'h1));
          if (m_drops < 255) m_drops++;
        end else begin
          wq.push_back(pk(c, {10'b0, 1'b1, m_bank, br(m_fill)}));
          if (m_fill == 15) begin
            if (m_out < 0 || is_out) begin
              start(c);
              started = 1;
            end else begin
              m_pend = 1;
              m_hold = 1;
            end
          end
          m_fill = m_fill + 1;
        end
      end
      if (is_out) begin
        if (m_pend) begin
          m_pend = 0;
          m_hold = 0;
          start(c);
        end else if (!started) m_out = -1;
      end
      if (wr_en || (wq.size() != 0 && wq[0][63:32] == c)) begin
        e = wq.size() != 0 ? wq.pop_front() : 64'h0;
        chk("wr", pk(c, {10'b0, wr_en, wr_bank, wr_addr}), e);
      end
      if (bf_start || (bq.size() != 0 && bq[0][63:32] == c)) begin
        e = bq.size() != 0 ? bq.pop_front() : 64'h0;
        chk("bf", pk(c, {3'b0, bf_start, cmp_bank, bf_addr_a, bf_addr_b, tw_idx}), e);
      end
      if (bf_we || (wbq.size() != 0 && wbq[0][63:32] == c)) begin
        e = wbq.size() != 0 ? wbq.pop_front() : 64'h0;
        chk("wb", pk(c, {7'b0, bf_we, wb_addr_a, wb_addr_b}), e);
      end
      if (fft_valid || (fq.size() != 0 && fq[0][63:32] == c)) begin
        e = fq.size() != 0 ? fq.pop_front() : 64'h0;
        chk("fft_valid", pk(c, {14'b0, fft_valid, cmp_bank}), e);
      end
      if (overrun || (oq.size() != 0 && oq[0][63:32] == c)) begin
        e = oq.size() != 0 ? oq.pop_front() : 64'h0;
        chk("overrun", pk(c, {15'b0, overrun}), e);
      end
    end
  end
  task automatic send(input int n);
    repeat (n) begin
      @(posedge clk);
      #1 dv = 1'b1;
    end
    @(posedge clk);
    #1 dv = 1'b0;
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask
  task automatic chk_zero(input string tag);
    chk(tag, {wr_en, wr_bank, wr_addr, cmp_bank, bf_start, bf_addr_a, bf_addr_b, tw_idx,
              bf_we, wb_addr_a, wb_addr_b, busy, fft_valid, overrun}, 64'h0);
  endtask
  initial begin
    idle(3);
    #1 chk_zero("reset_outs");
    rst = 1'b1;
    send(16);
    idle(50);
    send(48);
    idle(120);
    send(16);
    idle(60);
    send(16);
    idle(24);
    send(16);
    idle(60);
    send(16);
    idle(28);
    #2 rst = 1'b0;
    #1 chk_zero("async_reset_outs");
    idle(2);
    #1 rst = 1'b1;
    send(16);
    idle(50);
    for (int i = 0; i < 3; i++) begin
      send(16);
      idle(55);
    end
    chk("left_wr", wq.size(), 0);
    chk("left_bf", bq.size(), 0);
    chk("left_wb", wbq.size(), 0);
    chk("left_fft", fq.size(), 0);
    chk("left_ovr", oq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nv, nf);
    $finish;
  end
endmodule
